// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate controller: classifies fetched instructions,
// generates the immediate, and buffers results in a 2-entry skid buffer.

// Immediate generator: builds the extended immediate for the selected format.
module id_imm_immgen (
    input  logic [31:7] i_inst,
    input  logic [2:0]  i_imm_type,
    output logic [31:0] o_imm_c
);

    // Format select; the opcode bits never contribute to an immediate
    always_comb begin
        o_imm_c = 32'h0;
        case (i_imm_type)
            3'd0: o_imm_c = {{20{i_inst[31]}}, i_inst[31:20]};
            3'd1: o_imm_c = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            3'd2: o_imm_c = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                             i_inst[30:25], i_inst[11:8], 1'b0};
            3'd3: o_imm_c = {i_inst[31:12], 12'h000};
            3'd4: o_imm_c = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                             i_inst[20], i_inst[30:21], 1'b0};
            default: o_imm_c = 32'h0;
        endcase
    end

endmodule

module id_imm_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [PC_W-1:0]  out_pc,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_imm_type,
    output logic             out_has_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned TYPE_W = 3;

    localparam logic [TYPE_W-1:0] IMM_I = 3'd0;
    localparam logic [TYPE_W-1:0] IMM_S = 3'd1;
    localparam logic [TYPE_W-1:0] IMM_B = 3'd2;
    localparam logic [TYPE_W-1:0] IMM_U = 3'd3;
    localparam logic [TYPE_W-1:0] IMM_J = 3'd4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [31:0]       imm;
        logic [TYPE_W-1:0] imm_type;
        logic              has_imm;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_in_ready;
    logic               r_out_valid;
    entry_t             r_out;
    entry_t             r_skid;
    logic [CNT_W-1:0]   r_illegal_cnt;

    logic               w_has_imm;
    logic               w_illegal;
    logic [TYPE_W-1:0]  w_imm_type;
    logic [31:0]        w_imm_raw;
    entry_t             w_entry_in;
    logic               w_accept;
    logic               w_pop;
    logic               w_load_out_in;
    logic               w_load_out_skid;
    logic               w_load_skid;
    logic               w_cnt_inc;

    // Opcode classification; every legal opcode ends in 2'b11
    always_comb begin
        w_has_imm  = 1'b0;
        w_imm_type = IMM_I;
        w_illegal  = 1'b0;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                w_has_imm  = 1'b1;
                w_imm_type = IMM_I;
            end
            7'b0100011: begin
                w_has_imm  = 1'b1;
                w_imm_type = IMM_S;
            end
            7'b1100011: begin
                w_has_imm  = 1'b1;
                w_imm_type = IMM_B;
            end
            7'b0110111, 7'b0010111: begin
                w_has_imm  = 1'b1;
                w_imm_type = IMM_U;
            end
            7'b1101111: begin
                w_has_imm  = 1'b1;
                w_imm_type = IMM_J;
            end
            7'b0110011: begin
                w_has_imm  = 1'b0;
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase
    end

    id_imm_immgen u_immgen (
        .i_inst     (in_inst[31:7]),
        .i_imm_type (w_imm_type),
        .o_imm_c    (w_imm_raw)
    );

    // Entry assembled from the incoming instruction; immediate forced to 0 when absent
    always_comb begin
        w_entry_in          = '0;
        w_entry_in.inst     = in_inst;
        w_entry_in.pc       = in_pc;
        w_entry_in.imm      = w_has_imm ? w_imm_raw : 32'h0;
        w_entry_in.imm_type = w_imm_type;
        w_entry_in.has_imm  = w_has_imm;
        w_entry_in.illegal  = w_illegal;
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    // State register; ready/valid are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= (w_state_nx != ST_FULL);
            r_out_valid <= (w_state_nx != ST_EMPTY);
        end
    end

    // Next-state logic; flush overrides any accept or pop
    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nx = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_pop)      w_state_nx = ST_FULL;
                    else if (!w_accept && w_pop) w_state_nx = ST_EMPTY;
                end
                ST_FULL:  if (w_pop) w_state_nx = ST_ONE;
                default:  w_state_nx = ST_EMPTY;
            endcase
        end
    end

    // Datapath load controls per state
    always_comb begin
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        w_cnt_inc       = 1'b0;
        if (!flush) begin
            w_cnt_inc = w_accept && w_illegal;
            case (r_state)
                ST_EMPTY: w_load_out_in = w_accept;
                ST_ONE: begin
                    w_load_out_in = w_accept && w_pop;
                    w_load_skid   = w_accept && !w_pop;
                end
                ST_FULL:  w_load_out_skid = w_pop;
                default: begin
                    w_load_out_in = 1'b0;
                end
            endcase
        end
    end

    // Output and skid payload registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out <= w_entry_in;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry_in;
            end
        end
    end

    // Saturating count of accepted illegal encodings
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_cnt_inc && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_inst     = r_out.inst;
    assign out_pc       = r_out.pc;
    assign out_imm      = r_out.imm;
    assign out_imm_type = r_out.imm_type;
    assign out_has_imm  = r_out.has_imm;
    assign out_illegal  = r_out.illegal;
    assign illegal_cnt  = r_illegal_cnt;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Scoreboard bench for id_imm_ctrl: directed vectors with hand-computed
// immediates, plus a randomized valid/ready/flush run drawn from the same table.
module tb_id_imm_ctrl;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          NVEC    = 11;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [PC_W-1:0]  out_pc;
    logic [31:0]      out_imm;
    logic [2:0]       out_imm_type;
    logic             out_has_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    id_imm_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_has_imm  (out_has_imm),
        .out_illegal  (out_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  ty;
        logic        has;
        logic        ill;
    } vec_t;

    typedef struct packed {
        vec_t            v;
        logic [PC_W-1:0] pc;
    } exp_t;

    vec_t        tbl [NVEC];
    exp_t        sb [$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          cur_idx   = 0;
    int          model_cnt = 0;
    logic [31:0] pc_ctr    = 32'h0000_1000;

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0}; // addi x1,x0,-1
        tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 1'b1, 1'b0}; // sw
        tbl[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b0}; // beq
        tbl[3]  = '{32'h123450B7, 32'h12345000, 3'd3, 1'b1, 1'b0}; // lui
        tbl[4]  = '{32'h0080006F, 32'h00000008, 3'd4, 1'b1, 1'b0}; // jal +8
        tbl[5]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b0, 1'b1}; // all zero
        tbl[6]  = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b0, 1'b1}; // all ones
        tbl[7]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 1'b0}; // add
        tbl[8]  = '{32'h00812283, 32'h00000008, 3'd0, 1'b1, 1'b0}; // lw x5,8(x2)
        tbl[9]  = '{32'h00001517, 32'h00001000, 3'd3, 1'b1, 1'b0}; // auipc x10,1
        tbl[10] = '{32'h00000012, 32'h00000000, 3'd0, 1'b0, 1'b1}; // addi opcode with [1:0]=10
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue side: record the expected response of every accepted instruction
    always @(negedge clk) begin
        if (rst_n && !flush && in_valid && in_ready) begin
            sb.push_back('{tbl[cur_idx], in_pc});
            if (tbl[cur_idx].ill && model_cnt < CNT_MAX) model_cnt++;
        end
    end

    // Monitor: compare every delivered entry against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out actual inst=%08h pc=%08h expected=none",
                         out_inst, out_pc);
            end else begin
                e = sb.pop_front();
                if (out_inst !== e.v.inst || out_pc !== e.pc || out_imm !== e.v.imm ||
                    out_imm_type !== e.v.ty || out_has_imm !== e.v.has ||
                    out_illegal !== e.v.ill) begin
                    n_errors++;
                    $display("FAIL out_payload actual inst=%08h pc=%08h imm=%08h ty=%0d has=%0b ill=%0b expected inst=%08h pc=%08h imm=%08h ty=%0d has=%0b ill=%0b",
                             out_inst, out_pc, out_imm, out_imm_type, out_has_imm, out_illegal,
                             e.v.inst, e.pc, e.v.imm, e.v.ty, e.v.has, e.v.ill);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one table entry and hold it until accepted
    task automatic issue(input int idx);
        bit acc;
        bit done;
        done     = 1'b0;
        cur_idx  = idx;
        in_inst  = tbl[idx].inst;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout actual=not_accepted expected=accepted idx=%0d", idx);
        end
    endtask

    // Let the buffer empty out; an expired bound is a failure
    task automatic drain();
        bit done;
        done      = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout actual pending=%0d out_valid=%0b expected=empty",
                     sb.size(), out_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cyc(3);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        rst_n = 1'b1;
        cyc(1);

        // 1: single addi, one-cycle latency
        out_ready = 1'b1;
        issue(0);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_imm", 64'(out_imm), 64'hFFFFFFFF);
        chk("t1_type", 64'(out_imm_type), 64'd0);
        drain();

        // 2: streamed store then branch, in order
        issue(1);
        issue(2);
        drain();

        // 3: fill the buffer with out_ready low, check stall and stability
        out_ready = 1'b0;
        issue(3);
        issue(4);
        chk("t3_in_ready_full", 64'(in_ready), 64'd0);
        chk("t3_head_inst", 64'(out_inst), 64'h123450B7);
        held = out_imm;
        cyc(3);
        chk("t3_stable_imm", 64'(out_imm), 64'(held));
        chk("t3_stable_inst", 64'(out_inst), 64'h123450B7);
        chk("t3_still_full", 64'(in_ready), 64'd0);
        drain();

        // 4: flush while full with an illegal instruction presented
        out_ready = 1'b0;
        issue(3);
        issue(4);
        cur_idx  = 6;
        in_inst  = tbl[6].inst;
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_in_ready", 64'(in_ready), 64'd1);
        chk("t4_cnt", 64'(illegal_cnt), 64'd0);
        out_ready = 1'b1;
        cyc(3);
        chk("t4_nothing_out", 64'(out_valid), 64'd0);
        // flush beats a same-cycle accept from EMPTY
        cur_idx  = 5;
        in_inst  = tbl[5].inst;
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4b_out_valid", 64'(out_valid), 64'd0);
        chk("t4b_cnt", 64'(illegal_cnt), 64'd0);

        // 5: illegal encodings and counter saturation
        issue(5);
        issue(6);
        drain();
        chk("t5_cnt2", 64'(illegal_cnt), 64'd2);
        issue(10);
        drain();
        chk("t5_cnt3", 64'(illegal_cnt), 64'd3);
        for (int i = 0; i < 12; i++) issue(5);
        drain();
        chk("t5_cnt_max", 64'(illegal_cnt), 64'd15);
        issue(6);
        drain();
        chk("t5_cnt_sat", 64'(illegal_cnt), 64'd15);

        // 6: no-immediate R-type, then random traffic
        issue(7);
        issue(8);
        issue(9);
        drain();
        for (int c = 0; c < 400; c++) begin
            cur_idx   = int'($urandom_range(NVEC - 1, 0));
            in_inst   = tbl[cur_idx].inst;
            in_pc     = pc_ctr;
            pc_ctr    = pc_ctr + 32'd4;
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = ($urandom_range(3, 0) != 0);
            flush     = ($urandom_range(19, 0) == 0);
            cyc(1);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        chk("t6_cnt_model", 64'(illegal_cnt), 64'(model_cnt));

        // reset mid-operation drops buffered entries and clears the count
        out_ready = 1'b0;
        issue(0);
        issue(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n     = 1'b1;
        model_cnt = 0;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_cnt", 64'(illegal_cnt), 64'd0);
        issue(2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
